// File: rtl/program_counter_pkg.sv
// -----------------------------------------------------------------------------
// program_counter_pkg
// Shared datapath constants for the program counter.
//
// Contents:
//   PC_RESET_VALUE  address the PC returns to on reset (sized at the use site)
//   PC_WIDTH_MIN    smallest supported address width
//   PC_WIDTH_MAX    largest supported address width
// -----------------------------------------------------------------------------
package program_counter_pkg;

   localparam int PC_RESET_VALUE = 0;
   localparam int PC_WIDTH_MIN   = 2;
   localparam int PC_WIDTH_MAX   = 32;

endpackage : program_counter_pkg

// File: rtl/pc_next_logic.sv
// -----------------------------------------------------------------------------
// pc_next_logic
// Combinational next-address selection for the program counter.
// Load has priority over increment; with neither enable the PC holds.
// The increment wraps modulo 2^word_size (all-ones + 1 -> 0).
//
// Ports:
//   count       in   word_size  current PC value
//   d_in        in   word_size  jump/branch target
//   load_pc     in   1          select d_in
//   inc_pc      in   1          select count + 1
//   next_count  out  word_size  value to register on the next rising edge
// -----------------------------------------------------------------------------
module pc_next_logic #(
   parameter int word_size = 8
) (
   input  logic [word_size-1:0] count,
   input  logic [word_size-1:0] d_in,
   input  logic                 load_pc,
   input  logic                 inc_pc,
   output logic [word_size-1:0] next_count
);

   always_comb begin
      next_count = count;
      if (load_pc) begin
         next_count = d_in;
      end else if (inc_pc) begin
         // carry out of the top bit is intentionally dropped
         next_count = count + word_size'(1);
      end
   end

endmodule : pc_next_logic

// File: rtl/program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
// Address of the next instruction for the CPU fetch path. On each rising clk
// edge the PC is loaded from d_in, incremented by one, or held. An
// asynchronous active-high reset forces it to zero without a clock.
//
// Ports (positional order is fixed by existing instantiations):
//   count    out  word_size  current PC, straight from the register
//   d_in     in   word_size  load value (jump/branch target)
//   rst      in   1          asynchronous active-high reset
//   clk      in   1          system clock
//   load_pc  in   1          synchronous load enable (wins over inc_pc)
//   inc_pc   in   1          synchronous increment enable
//
// Parameter:
//   word_size  address width, 2..32
// -----------------------------------------------------------------------------
module program_counter
   import program_counter_pkg::*;
#(
   parameter int word_size = 8
) (
   output logic [word_size-1:0] count,
   input  logic [word_size-1:0] d_in,
   input  logic                 rst,
   input  logic                 clk,
   input  logic                 load_pc,
   input  logic                 inc_pc
);

   logic [word_size-1:0] next_count;

   pc_next_logic #(
      .word_size (word_size)
   ) u_next (
      .count      (count),
      .d_in       (d_in),
      .load_pc    (load_pc),
      .inc_pc     (inc_pc),
      .next_count (next_count)
   );

   // Reset is in the sensitivity list so count clears as soon as rst rises
   // and stays clear while it is high, whatever the other inputs are doing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= word_size'(PC_RESET_VALUE);
      end else begin
         count <= next_count;
      end
   end

endmodule : program_counter

// File: tb/tb_program_counter.sv
module tb_program_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] d_in;
   logic       load_pc;
   logic       inc_pc;
   logic [7:0] count;

   logic       rst4;
   logic [3:0] d_in4;
   logic       load4;
   logic       inc4;
   logic [3:0] count4;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   program_counter #(.word_size(8)) dut (
      .count   (count),
      .d_in    (d_in),
      .rst     (rst),
      .clk     (clk),
      .load_pc (load_pc),
      .inc_pc  (inc_pc)
   );

   program_counter #(.word_size(4)) dut4 (
      .count   (count4),
      .d_in    (d_in4),
      .rst     (rst4),
      .clk     (clk),
      .load_pc (load4),
      .inc_pc  (inc4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic l, input logic i, input logic [7:0] d);
      load_pc = l;
      inc_pc  = i;
      d_in    = d;
   endtask

   logic [7:0] inc_exp [3];
   logic [7:0] wrap_exp[3];

   initial begin
      inc_exp  = '{8'h11, 8'h12, 8'h13};
      wrap_exp = '{8'hFF, 8'h00, 8'h01};

      rst  = 1'b1;
      rst4 = 1'b1;
      drive(1'b1, 1'b1, 8'hFF);
      d_in4 = 4'hF; load4 = 1'b1; inc4 = 1'b1;

      // reset dominance
      for (int k = 0; k < 3; k++) begin
         tick();
         check("rst_dom_load", {24'd0, count}, 32'h00);
         check("rst_dom_w4", {28'd0, count4}, 32'h0);
      end
      drive(1'b0, 1'b1, 8'hFF);
      tick();
      check("rst_dom_inc", {24'd0, count}, 32'h00);

      // release: holds zero until an enabled edge
      rst = 1'b0;
      drive(1'b0, 1'b0, 8'hAA);
      tick();
      check("release_hold", {24'd0, count}, 32'h00);

      // load, then load over increment
      drive(1'b1, 1'b0, 8'h3C);
      tick();
      check("load_3c", {24'd0, count}, 32'h3C);
      drive(1'b1, 1'b1, 8'h10);
      tick();
      check("load_over_inc", {24'd0, count}, 32'h10);

      // increment then hold
      drive(1'b0, 1'b1, 8'hEE);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("inc", {24'd0, count}, {24'd0, inc_exp[k]});
      end
      drive(1'b0, 1'b0, 8'hEE);
      for (int k = 0; k < 2; k++) begin
         tick();
         check("hold", {24'd0, count}, 32'h13);
      end

      // no combinational path from d_in/enables to count
      #1;
      drive(1'b1, 1'b1, 8'h99);
      #1;
      check("no_comb_path", {24'd0, count}, 32'h13);

      // wrap-around
      drive(1'b1, 1'b0, 8'hFE);
      tick();
      check("load_fe", {24'd0, count}, 32'hFE);
      drive(1'b0, 1'b1, 8'h00);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("wrap", {24'd0, count}, {24'd0, wrap_exp[k]});
      end

      // async reset mid-cycle
      drive(1'b1, 1'b0, 8'h5A);
      tick();
      check("load_5a", {24'd0, count}, 32'h5A);
      drive(1'b1, 1'b1, 8'h77);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst", {24'd0, count}, 32'h00);
      tick();
      check("rst_over_pending", {24'd0, count}, 32'h00);
      rst = 1'b0;
      drive(1'b0, 1'b0, 8'h77);
      tick();
      check("post_rst_hold", {24'd0, count}, 32'h00);
      drive(1'b0, 1'b1, 8'h77);
      tick();
      check("post_rst_inc", {24'd0, count}, 32'h01);

      // 4-bit instance
      rst4 = 1'b0;
      load4 = 1'b1; inc4 = 1'b0; d_in4 = 4'hF;
      tick();
      check("w4_load_f", {28'd0, count4}, 32'hF);
      load4 = 1'b0; inc4 = 1'b1;
      tick();
      check("w4_wrap", {28'd0, count4}, 32'h0);
      tick();
      check("w4_inc", {28'd0, count4}, 32'h1);
      #2;
      rst4 = 1'b1;
      #1;
      check("w4_async_rst", {28'd0, count4}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule : tb_program_counter

// File: doc/program_counter.md
Name: program_counter

Overview:
- Parameterised program counter for the simple CPU datapath.
- Holds the address of the next instruction; fetch logic reads it as `count`.
- Each rising clock edge it can be loaded from `d_in` (jump/branch target), incremented by one (sequential fetch) or held.
- Asynchronous active-high reset forces it to zero.

Parameters:
- word_size, 8, width in bits of `d_in` and `count` (address width); legal range 2..32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge except reset.
- rst  input  1  asynchronous, active-high reset; forces `count` to 0 while high.
- count  output  word_size  current PC value, driven directly from the register.
- d_in  input  word_size  value to load when `load_pc` is high.
- load_pc  input  1  synchronous load enable.
- inc_pc  input  1  synchronous increment enable.
- Positional port order is fixed for existing instantiations: count, d_in, rst, clk, load_pc, inc_pc.

Behaviour:
- Reset:
  - `rst` high forces `count` = 0 immediately, with no clock required.
  - `count` stays 0 for as long as `rst` is high, regardless of `load_pc`, `inc_pc` or `d_in`.
  - Release is synchronous in effect: the first update happens at the first rising `clk` edge after `rst` falls.
  - Reset asserted mid-operation overrides any pending load or increment.
- Priority at each rising `clk` edge with `rst` low:
  - `load_pc`=1: `count` <= `d_in`. Load wins over increment when both are high.
  - else `inc_pc`=1: `count` <= `count` + 1, modulo 2^word_size.
  - else: `count` holds.
- Wrap-around: all-ones + 1 -> 0. No carry/overflow output, no saturation.
- Latency:
  - Load/increment result is visible on `count` one clock edge after the enables are sampled.
  - No combinational path from `d_in`, `load_pc` or `inc_pc` to `count`.
- Output: `count` is a registered output with no glitches other than the async reset transition.
- Unknown inputs: with `rst` high, `count` is 0 even if the other inputs are X.

Decomposition:
- Package: no shared typedefs required.
  - An optional package constant `PC_RESET_VALUE` = 0, width word_size, may be used if the CPU package already holds datapath constants.
- Single module, no sub-module required.
- The next-value mux may be written inline or factored into a combinational helper `pc_next_logic`, taking count, d_in, load_pc, inc_pc and producing the next value.

Test Plan:
- Reset dominance: rst=1, d_in=8'hFF, load_pc=1, inc_pc=1 for several clocks -> count stays 8'h00. Then load_pc=0, inc_pc=1, rst still 1 -> count stays 8'h00.
- Async reset:
  - Load 8'h5A.
  - Assert rst between clock edges -> count = 8'h00 before the next rising edge.
  - Deassert rst -> count holds 0 until the first enabled edge.
- Load and load-over-increment:
  - rst=0, d_in=8'h3C, load_pc=1, inc_pc=0, one edge -> count = 8'h3C.
  - Then d_in=8'h10, load_pc=1, inc_pc=1, one edge -> count = 8'h10.
- Increment and hold:
  - From 8'h10, inc_pc=1 for 3 edges -> 8'h11, 8'h12, 8'h13.
  - Then inc_pc=0, load_pc=0 for 2 edges -> stays 8'h13.
- Wrap-around: load 8'hFE, inc_pc=1 for 3 edges -> 8'hFF, 8'h00, 8'h01.
- Parameter check: word_size=4, load 4'hF, increment once -> count = 4'h0; reset -> 4'h0.
